uart_rx: RTL and testbench

- Serial receiver for the CSCvon8 console; the input-side partner of the existing output-only UART.
- Deserialises 8N1 frames from an asynchronous RX pin into a one-byte holding register.
- Drives the data bus when the data-bus writer selects the UART source (DbusOp 2'b10). This replaces the hard-coded 8'h3f input value.
- Provides active-high status lines to the two currently-grounded UART inputs of the jump multiplexer.

---
 rtl/uart_rx.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver for the CSCvon8 console: two-flop synchroniser, mid-bit sampling FSM,
// one-byte holding register driven onto the data bus while rd_n is low, plus sticky status flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int WordSize     = 8
) (
  input  logic                i_clk,
  input  logic                reset,
  input  logic                rxd,
  input  logic                rd_n,
  output logic [WordSize-1:0] dout,
  output logic                rx_ready,
  output logic                rx_overrun,
  output logic                frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic [1:0]          rxd_sync_r;
  logic                rxd_s;
  state_t              state_r, state_s;
  logic [CW-1:0]       cnt_r, cnt_s;
  logic [2:0]          bidx_r, bidx_s;
  logic [WordSize-1:0] shift_r, shift_s;
  logic                byte_done_s, stop_err_s;
  logic                rd_prev_r, consume_s;
  logic [WordSize-1:0] hold_r, hold_s;
  logic                ready_r, ready_s;
  logic                ovr_r, ovr_s;
  logic                ferr_r, ferr_s;

  assign rxd_s     = rxd_sync_r[1];
  assign consume_s = ~rd_n & rd_prev_r;

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      rxd_sync_r <= 2'b11;
    end else begin
      rxd_sync_r <= {rxd_sync_r[0], rxd};
    end
  end

  // Frame FSM: start-bit qualification at half a bit, then one sample per bit period.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    bidx_s      = bidx_r;
    shift_s     = shift_r;
    byte_done_s = 1'b0;
    stop_err_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rxd_s) begin
          state_s = ST_START;
          cnt_s   = {CW{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_s  = {CW{1'b0}};
          bidx_s = 3'd0;
          if (!rxd_s) begin
            state_s = ST_DATA;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s   = {CW{1'b0}};
          shift_s = {rxd_s, shift_r[WordSize-1:1]};
          bidx_s  = bidx_r + 3'd1;
          if (bidx_r == 3'd7) begin
            state_s = ST_STOP;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s = {CW{1'b0}};
          if (rxd_s) begin
            byte_done_s = 1'b1;
            state_s     = ST_IDLE;
          end else begin
            stop_err_s = 1'b1;
            state_s    = ST_BREAK;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_BREAK: begin
        // A held-low line must not be mistaken for a stream of zero bytes.
        if (rxd_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BREAK;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // Frame FSM state, counters and shift register.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      bidx_r  <= 3'd0;
      shift_r <= {WordSize{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bidx_r  <= bidx_s;
      shift_r <= shift_s;
    end
  end

  // Holding register and flags; a completing byte may replace the one being consumed this cycle.
  always_comb begin
    hold_s  = hold_r;
    ready_s = ready_r & ~consume_s;
    ovr_s   = ovr_r & ~consume_s;
    ferr_s  = (ferr_r & ~consume_s) | stop_err_s;
    if (byte_done_s && (!ready_r || consume_s)) begin
      hold_s  = shift_r;
      ready_s = 1'b1;
    end else if (byte_done_s) begin
      ovr_s = 1'b1;
    end else begin
      hold_s = hold_r;
    end
  end

  // Status registers and read-strobe edge detector.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      rd_prev_r <= 1'b1;
      hold_r    <= {WordSize{1'b0}};
      ready_r   <= 1'b0;
      ovr_r     <= 1'b0;
      ferr_r    <= 1'b0;
    end else begin
      rd_prev_r <= rd_n;
      hold_r    <= hold_s;
      ready_r   <= ready_s;
      ovr_r     <= ovr_s;
      ferr_r    <= ferr_s;
    end
  end

  assign rx_ready   = ready_r;
  assign rx_overrun = ovr_r;
  assign frame_err  = ferr_r;
  assign dout       = rd_n ? {WordSize{1'bz}} : hold_r;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: randomized and directed frames against a frame-level reference model.
module tb_uart_rx;
  localparam int CPB = 16;
  // Line falls -> two synchroniser flops -> IDLE detect, then half a bit plus nine bit periods.
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;

  logic       i_clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic       rd_n;
  wire  [7:0] dout;
  logic       rx_ready;
  logic       rx_overrun;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] m_hold;
  logic       m_ready, m_ovr, m_ferr;
  int         rise_q[$];
  logic [7:0] rd_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB), .WordSize(8)) dut (
    .i_clk(i_clk), .reset(reset), .rxd(rxd), .rd_n(rd_n), .dout(dout),
    .rx_ready(rx_ready), .rx_overrun(rx_overrun), .frame_err(frame_err)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".rx_ready"}, {31'd0, rx_ready}, {31'd0, m_ready});
    check({tag, ".rx_overrun"}, {31'd0, rx_overrun}, {31'd0, m_ovr});
    check({tag, ".frame_err"}, {31'd0, frame_err}, {31'd0, m_ferr});
  endtask

  // Monitor: pops expectations when rx_ready rises or when a read strobe starts.
  logic prev_ready = 1'b0;
  logic prev_rd = 1'b1;
  int   e_cyc;
  logic [7:0] e_byte;
  always @(negedge i_clk) begin
    #2;
    if (rx_ready && !prev_ready) begin
      if (rise_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready: rx_ready rose at cycle %0d with nothing expected", cyc);
      end else begin
        e_cyc = rise_q.pop_front();
        check("ready_latency", cyc, e_cyc);
      end
    end
    if (!rd_n && prev_rd) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read: strobe at cycle %0d with nothing expected", cyc);
      end else begin
        e_byte = rd_q.pop_front();
        check("dout", {24'd0, dout}, {24'd0, e_byte});
      end
    end
    prev_ready = rx_ready;
    prev_rd    = rd_n;
  end

  task automatic send_line(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (CPB) @(negedge i_clk);
    end
  endtask

  task automatic frame(input logic [7:0] b, input logic ok, input int brk);
    @(negedge i_clk);
    if (ok) begin
      if (!m_ready) begin
        m_hold  = b;
        m_ready = 1'b1;
        rise_q.push_back(cyc + LAT);
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      m_ferr = 1'b1;
    end
    send_line(b, ok);
    if (!ok) repeat (brk) @(negedge i_clk);
    rxd = 1'b1;
    repeat (6) @(negedge i_clk);
    #2;
    check_flags("frame");
  endtask

  task automatic read_pulse(input int n);
    @(negedge i_clk);
    rd_q.push_back(m_hold);
    rd_n = 1'b0;
    repeat (n) @(negedge i_clk);
    rd_n    = 1'b1;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    #2;
    check_flags("read");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; rxd = 1'b1; rd_n = 1'b1;
    m_hold = 8'h00; m_ready = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    repeat (3) @(negedge i_clk);
    #1;
    check_flags("reset");
    reset = 1'b1;
    repeat (4) @(negedge i_clk);

    // Basic byte and read.
    frame(8'h41, 1'b1, 0);
    read_pulse(1);

    // Short low glitch must be rejected.
    @(negedge i_clk);
    rxd = 1'b0;
    repeat (4) @(negedge i_clk);
    rxd = 1'b1;
    repeat (20) @(negedge i_clk);
    #2;
    check_flags("glitch");
    frame(8'hA5, 1'b1, 0);
    read_pulse(2);

    // Framing error followed by a good byte.
    frame(8'h3C, 1'b0, 40);
    frame(8'h55, 1'b1, 0);
    read_pulse(1);

    // Overrun: second byte lost, first byte kept.
    frame(8'h11, 1'b1, 0);
    frame(8'h22, 1'b1, 0);
    read_pulse(3);

    // Consume exactly on the completion edge of a new byte.
    frame(8'h66, 1'b1, 0);
    @(negedge i_clk);
    fork
      send_line(8'h77, 1'b1);
      begin
        repeat (LAT - 1) @(negedge i_clk);
        rd_q.push_back(m_hold);
        rd_n = 1'b0;
        @(negedge i_clk);
        #2;
        check("coincide_dout", {24'd0, dout}, 32'h0000_0077);
        rd_n = 1'b1;
      end
    join
    rxd = 1'b1;
    m_hold = 8'h77; m_ready = 1'b1; m_ovr = 1'b0; m_ferr = 1'b0;
    repeat (4) @(negedge i_clk);
    #2;
    check_flags("coincide");
    read_pulse(1);

    // Set every flag, then reset in the middle of a frame.
    frame(8'h5A, 1'b1, 0);
    frame(8'h5B, 1'b0, 10);
    frame(8'h5C, 1'b1, 0);
    @(negedge i_clk);
    fork
      send_line(8'hF0, 1'b1);
      begin
        repeat (5 * CPB + 4) @(negedge i_clk);
        reset = 1'b0;
        m_hold = 8'h00; m_ready = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
        #1;
        check_flags("async_reset");
        repeat (3) @(negedge i_clk);
        reset = 1'b1;
      end
    join
    rxd = 1'b1;
    repeat (CPB * 12) @(negedge i_clk);
    #2;
    check_flags("after_reset");
    read_pulse(1);
    frame(8'hC3, 1'b1, 0);
    read_pulse(1);

    // Randomized frames, errors and reads.
    for (int k = 0; k < 24; k++) begin
      frame(8'($urandom_range(0, 255)), ($urandom_range(0, 5) != 0), $urandom_range(1, 30));
      if ($urandom_range(0, 2) != 0) read_pulse($urandom_range(1, 4));
    end
    read_pulse(1);

    repeat (4) @(negedge i_clk);
    #3;
    check("rise_q_empty", rise_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
